// File: rtl/uart_rx_fifo.sv
// Receive-side circular FIFO between the UART Receiver and the host read port.
// Define UART_RX_FIFO_AF_EN to add the registered o_almost_full output (count >= AF_LEVEL).
module uart_rx_fifo #(
    parameter int SIZE_DATA = 8,
    parameter int DEPTH     = 16,
    parameter int AF_LEVEL  = 12
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic [SIZE_DATA-1:0]     i_wr_data,
    input  logic                     i_wr_en,
    output logic                     o_fifo_full,
    input  logic                     i_rd_en,
    output logic [SIZE_DATA-1:0]     o_rd_data,
    output logic                     o_rd_valid,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_overrun,
`ifdef UART_RX_FIFO_AF_EN
    output logic                     o_almost_full,
`endif
    input  logic                     i_clr_overrun
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    logic [SIZE_DATA-1:0] mem_reg [DEPTH];
    logic [PTR_W-1:0]     wr_ptr_reg;
    logic [PTR_W-1:0]     rd_ptr_reg;
    logic [CNT_W-1:0]     count_reg;
    logic [CNT_W-1:0]     count_next;
    logic [SIZE_DATA-1:0] rd_data_reg;
    logic                 rd_valid_reg;
    logic                 overrun_reg;
    logic                 rd_accept;
    logic                 wr_accept;
    logic                 wr_drop;

    // A write into a full FIFO only succeeds when a read frees a slot in the same cycle.
    assign rd_accept = i_rd_en && (count_reg != '0);
    assign wr_accept = i_wr_en && ((count_reg != FULL_COUNT) || rd_accept);
    assign wr_drop   = i_wr_en && !wr_accept;

    always_comb begin
        count_next = count_reg;
        if (wr_accept && !rd_accept) begin
            count_next = count_reg + 1'b1;
        end else if (rd_accept && !wr_accept) begin
            count_next = count_reg - 1'b1;
        end
    end

    // Storage carries no reset; stale entries are unreachable once the pointers reset.
    always_ff @(posedge i_clk) begin
        if (!i_rst && wr_accept) begin
            mem_reg[wr_ptr_reg] <= i_wr_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            rd_data_reg  <= '0;
            rd_valid_reg <= 1'b0;
            overrun_reg  <= 1'b0;
        end else begin
            count_reg    <= count_next;
            rd_valid_reg <= rd_accept;
            if (wr_accept) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (rd_accept) begin
                rd_ptr_reg  <= rd_ptr_reg + 1'b1;
                rd_data_reg <= mem_reg[rd_ptr_reg];
            end
            // Set has priority over clear so a simultaneous drop is never lost.
            if (wr_drop) begin
                overrun_reg <= 1'b1;
            end else if (i_clr_overrun) begin
                overrun_reg <= 1'b0;
            end
        end
    end

`ifdef UART_RX_FIFO_AF_EN
    logic almost_full_reg;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            almost_full_reg <= 1'b0;
        end else begin
            almost_full_reg <= (count_next >= CNT_W'(AF_LEVEL));
        end
    end

    assign o_almost_full = almost_full_reg;
`endif

    assign o_count     = count_reg;
    assign o_empty     = (count_reg == '0);
    assign o_fifo_full = (count_reg == FULL_COUNT);
    assign o_rd_data   = rd_data_reg;
    assign o_rd_valid  = rd_valid_reg;
    assign o_overrun   = overrun_reg;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed self-checking bench for uart_rx_fifo (DEPTH=16, SIZE_DATA=8, AF_LEVEL=12).
module tb_uart_rx_fifo;

    logic       clk;
    logic       rst;
    logic [7:0] wr_data;
    logic       wr_en;
    logic       fifo_full;
    logic       rd_en;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       empty;
    logic [4:0] count;
    logic       overrun;
    logic       clr_overrun;
`ifdef UART_RX_FIFO_AF_EN
    logic       almost_full;
`endif

    int checks = 0;
    int errors = 0;

    uart_rx_fifo #(.SIZE_DATA(8), .DEPTH(16), .AF_LEVEL(12)) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_wr_data     (wr_data),
        .i_wr_en       (wr_en),
        .o_fifo_full   (fifo_full),
        .i_rd_en       (rd_en),
        .o_rd_data     (rd_data),
        .o_rd_valid    (rd_valid),
        .o_empty       (empty),
        .o_count       (count),
        .o_overrun     (overrun),
`ifdef UART_RX_FIFO_AF_EN
        .o_almost_full (almost_full),
`endif
        .i_clr_overrun (clr_overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock with the given inputs; outputs are sampled 1 ns after the edge.
    task automatic cyc(input logic w, input logic [7:0] d, input logic r, input logic c);
        wr_en       = w;
        wr_data     = d;
        rd_en       = r;
        clr_overrun = c;
        @(posedge clk);
        #1;
        wr_en       = 1'b0;
        rd_en       = 1'b0;
        clr_overrun = 1'b0;
    endtask

    initial begin
        rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; clr_overrun = 1'b0; wr_data = 8'h00;

        // 1. Reset for 3 cycles with write pulses that must be ignored
        for (int i = 0; i < 3; i++) cyc(1'b1, 8'h77, 1'b0, 1'b0);
        rst = 1'b0;
        chk("rst_empty", empty, 1);
        chk("rst_count", count, 0);
        chk("rst_full", fifo_full, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_rd_data", rd_data, 8'h00);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        chk("rst_no_store_valid", rd_valid, 0);
        $display("reset/idle done count=%0d empty=%0b", count, empty);

        // 2. Single byte
        cyc(1'b1, 8'h55, 1'b0, 1'b0);
        chk("single_count", count, 1);
        chk("single_empty", empty, 0);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        chk("single_valid", rd_valid, 1);
        chk("single_data", rd_data, 8'h55);
        chk("single_empty_after", empty, 1);
        $display("single byte rd_data=%02h valid=%0b", rd_data, rd_valid);
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        chk("single_valid_pulse", rd_valid, 0);
        chk("single_data_hold", rd_data, 8'h55);

        // 3. Fill and wrap
        for (int i = 0; i < 16; i++) begin
            cyc(1'b1, 8'(i), 1'b0, 1'b0);
            if (i == 14) begin
                chk("fill_count15", count, 15);
                chk("fill_notfull15", fifo_full, 0);
            end
        end
        chk("fill_full", fifo_full, 1);
        chk("fill_count16", count, 16);
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 8'h00, 1'b1, 1'b0);
            chk("wrap_rd_valid", rd_valid, 1);
            chk("wrap_rd_data", rd_data, 32'(i));
            $display("read %0d data=%02h", i, rd_data);
        end
        chk("wrap_count12", count, 12);
        for (int i = 0; i < 4; i++) cyc(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
        chk("wrap_full_again", fifo_full, 1);
        for (int i = 0; i < 16; i++) begin
            cyc(1'b0, 8'h00, 1'b1, 1'b0);
            chk("drain_rd_valid", rd_valid, 1);
            chk("drain_rd_data", rd_data, 32'(4 + i));
            $display("drain %0d data=%02h", i, rd_data);
        end
        chk("drain_empty", empty, 1);
        chk("drain_count", count, 0);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        chk("empty_read_ignored", rd_valid, 0);
        chk("empty_read_data_hold", rd_data, 8'h13);

        // 4. Overrun
        for (int i = 0; i < 16; i++) cyc(1'b1, 8'(8'h20 + i), 1'b0, 1'b0);
        chk("ovr_pre_flag", overrun, 0);
        cyc(1'b1, 8'hAA, 1'b0, 1'b0);
        chk("ovr_set", overrun, 1);
        chk("ovr_count", count, 16);
        cyc(1'b1, 8'hAB, 1'b0, 1'b1);
        chk("ovr_set_wins", overrun, 1);
        cyc(1'b0, 8'h00, 1'b0, 1'b1);
        chk("ovr_cleared", overrun, 0);
        $display("overrun sequence count=%0d overrun=%0b", count, overrun);

        // 5a. Full with simultaneous write and read
        cyc(1'b1, 8'hBB, 1'b1, 1'b0);
        chk("fullwr_rd_valid", rd_valid, 1);
        chk("fullwr_rd_data", rd_data, 8'h20);
        chk("fullwr_count", count, 16);
        chk("fullwr_overrun", overrun, 0);
        for (int i = 0; i < 16; i++) begin
            cyc(1'b0, 8'h00, 1'b1, 1'b0);
            chk("fullwr_drain", rd_data, (i < 15) ? 32'(8'h21 + i) : 32'h0BB);
            $display("drain2 %0d data=%02h", i, rd_data);
        end
        chk("fullwr_empty", empty, 1);

        // 5b. Empty with simultaneous write and read: no bypass
        cyc(1'b1, 8'hCC, 1'b1, 1'b0);
        chk("emptywr_rd_valid", rd_valid, 0);
        chk("emptywr_count", count, 1);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        chk("emptywr_data", rd_data, 8'hCC);
        chk("emptywr_valid", rd_valid, 1);
        $display("empty wr+rd then read data=%02h", rd_data);

        // 6. Reset mid-operation
        for (int i = 0; i < 7; i++) cyc(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
        chk("mid_count7", count, 7);
        rst = 1'b1;
        cyc(1'b1, 8'h99, 1'b1, 1'b0);
        rst = 1'b0;
        chk("mid_rst_count", count, 0);
        chk("mid_rst_empty", empty, 1);
        chk("mid_rst_valid", rd_valid, 0);
        chk("mid_rst_data", rd_data, 8'h00);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        chk("mid_rst_read_none", rd_valid, 0);
        $display("mid reset count=%0d empty=%0b", count, empty);

`ifdef UART_RX_FIFO_AF_EN
        chk("af_reset", almost_full, 0);
        for (int i = 0; i < 11; i++) cyc(1'b1, 8'(i), 1'b0, 1'b0);
        chk("af_at11", almost_full, 0);
        cyc(1'b1, 8'h0B, 1'b0, 1'b0);
        chk("af_at12", almost_full, 1);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        chk("af_back11", almost_full, 0);
        $display("almost_full checks count=%0d af=%0b", count, almost_full);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
